// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I datapath. It sequences fetch, decode, exec, mem and wb over one shared memory port.
// Zero-wait latency: R/I-ALU 4, LOAD 5, STORE 4, BRANCH 3 cycles. FETCH and MEM hold while memReady is low.
module multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic        memReady,
  input  logic        branchTaken,
  output logic        memReq,
  output logic        memWrite,
  output logic        iord,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic        regWrite,
  output logic        memToReg,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BR     = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  logic [2:0]  state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;
  logic        op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= 7'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
    end
  end

  // Every path back to FETCH except reset retires exactly one instruction.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    retire   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (memReady) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        opcode_d = opcode;
        state_d  = op_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        case (opcode_q)
          OP_R, OP_I:         state_d = ST_WB;
          OP_LOAD, OP_STORE:  state_d = ST_MEM;
          OP_BRANCH: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default:            state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (memReady) begin
          if (opcode_q == OP_STORE) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      default: state_d = ST_TRAP;
    endcase
    retired_d = retired_q + {31'd0, retire};
  end

  // Controls are forced low during reset so an in-flight access is dropped that same cycle.
  always_comb begin
    memReq   = 1'b0;
    memWrite = 1'b0;
    iord     = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 1'b0;
    aluSrcA  = SRCA_PC;
    aluSrcB  = SRCB_REG;
    aluOp    = ALU_ADD;
    regWrite = 1'b0;
    memToReg = 1'b0;
    illegal  = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_FETCH: begin
          memReq  = 1'b1;
          aluSrcA = SRCA_PC;
          aluSrcB = SRCB_FOUR;
          aluOp   = ALU_ADD;
          irWrite = memReady;
          pcWrite = memReady;
        end
        ST_DECODE: begin
          aluSrcA = SRCA_OLDPC;
          aluSrcB = SRCB_IMM;
          aluOp   = ALU_ADD;
        end
        ST_EXEC: begin
          case (opcode_q)
            OP_R: begin
              aluSrcA = SRCA_REG;
              aluSrcB = SRCB_REG;
              aluOp   = ALU_FUNCT;
            end
            OP_I: begin
              aluSrcA = SRCA_REG;
              aluSrcB = SRCB_IMM;
              aluOp   = ALU_FUNCT;
            end
            OP_LOAD, OP_STORE: begin
              aluSrcA = SRCA_REG;
              aluSrcB = SRCB_IMM;
              aluOp   = ALU_ADD;
            end
            OP_BRANCH: begin
              aluSrcA = SRCA_REG;
              aluSrcB = SRCB_REG;
              aluOp   = ALU_BR;
              pcWrite = branchTaken;
              pcSrc   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          memReq   = 1'b1;
          iord     = 1'b1;
          memWrite = (opcode_q == OP_STORE);
        end
        ST_WB: begin
          regWrite = 1'b1;
          memToReg = (opcode_q == OP_LOAD);
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
